// File: rtl/clock_pkg.sv
// Shared types and constants for the 12-hour time-of-day counter.
// Holds the BCD digit type, reset time and default wrap limits.
package clock_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t RESET_HOUR_TENS = 4'd1;
  localparam bcd_t RESET_HOUR_ONES = 4'd2;

  localparam int unsigned SEC_MAX_DEFAULT  = 59;
  localparam int unsigned MIN_MAX_DEFAULT  = 59;
  localparam int unsigned HOUR_MAX_DEFAULT = 12;

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that counts 00..MAX and wraps to 00.
// The wrap pulse is combinational so the next stage can carry in the same cycle.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter int unsigned MAX = 59
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output bcd_t ones,
  output bcd_t tens,
  output logic wrap
);

  localparam bcd_t MAX_ONES = bcd_t'(MAX % 10);
  localparam bcd_t MAX_TENS = bcd_t'(MAX / 10);

  logic at_max;

  assign at_max = (ones == MAX_ONES) && (tens == MAX_TENS);
  assign wrap   = inc && at_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones <= '0;
      tens <= '0;
    end else if (clr) begin
      ones <= '0;
      tens <= '0;
    end else if (inc) begin
      if (at_max) begin
        ones <= '0;
        tens <= '0;
      end else if (ones == 4'd9) begin
        ones <= '0;
        tens <= tens + 4'd1;
      end else begin
        ones <= ones + 4'd1;
      end
    end
  end

endmodule

// File: rtl/time_keeper.sv
// 12-hour hh:mm:ss AM/PM clock driven by a 1 Hz enable pulse, BCD outputs.
// Define TIME_SET_EN to enable set_mode/inc_min/inc_hour; otherwise they are ignored.
module time_keeper
  import clock_pkg::*;
#(
  parameter int unsigned SEC_MAX  = SEC_MAX_DEFAULT,
  parameter int unsigned MIN_MAX  = MIN_MAX_DEFAULT,
  parameter int unsigned HOUR_MAX = HOUR_MAX_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable_second,
  input  logic       set_mode,
  input  logic       inc_min,
  input  logic       inc_hour,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic [3:0] hour_ones,
  output logic [3:0] hour_tens,
  output logic       pm,
  output logic       minute_tick
);

  localparam bcd_t HOUR_MAX_ONES = bcd_t'(HOUR_MAX % 10);
  localparam bcd_t HOUR_MAX_TENS = bcd_t'(HOUR_MAX / 10);

  logic set_active;
  logic set_inc_min;
  logic set_inc_hour;

`ifdef TIME_SET_EN
  assign set_active   = set_mode;
  assign set_inc_min  = set_mode && inc_min;
  assign set_inc_hour = set_mode && inc_hour;
`else
  logic unused_set_inputs;
  assign unused_set_inputs = set_mode ^ inc_min ^ inc_hour;
  assign set_active   = 1'b0;
  assign set_inc_min  = 1'b0;
  assign set_inc_hour = 1'b0;
`endif

  logic sec_inc;
  logic sec_wrap;
  logic min_inc;
  logic min_wrap;
  logic hour_inc;

  // While setting, seconds are held at zero and the minute wrap must not reach the hours.
  assign sec_inc  = enable_second && !set_active;
  assign min_inc  = set_active ? set_inc_min  : sec_wrap;
  assign hour_inc = set_active ? set_inc_hour : min_wrap;

  bcd_mod_counter #(.MAX(SEC_MAX)) u_seconds (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (sec_inc),
    .clr   (set_active),
    .ones  (sec_ones),
    .tens  (sec_tens),
    .wrap  (sec_wrap)
  );

  bcd_mod_counter #(.MAX(MIN_MAX)) u_minutes (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (min_inc),
    .clr   (1'b0),
    .ones  (min_ones),
    .tens  (min_tens),
    .wrap  (min_wrap)
  );

  bcd_t hour_ones_next;
  bcd_t hour_tens_next;
  logic pm_toggle;

  // Hours run 1..HOUR_MAX; the meridiem flips on arrival at HOUR_MAX, not on the rollover to 01.
  always_comb begin
    hour_ones_next = hour_ones + 4'd1;
    hour_tens_next = hour_tens;
    if ((hour_tens == HOUR_MAX_TENS) && (hour_ones == HOUR_MAX_ONES)) begin
      hour_ones_next = 4'd1;
      hour_tens_next = 4'd0;
    end else if (hour_ones == 4'd9) begin
      hour_ones_next = 4'd0;
      hour_tens_next = hour_tens + 4'd1;
    end
    pm_toggle = (hour_tens_next == HOUR_MAX_TENS) && (hour_ones_next == HOUR_MAX_ONES);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hour_tens   <= RESET_HOUR_TENS;
      hour_ones   <= RESET_HOUR_ONES;
      pm          <= 1'b0;
      minute_tick <= 1'b0;
    end else begin
      minute_tick <= sec_wrap;
      if (hour_inc) begin
        hour_tens <= hour_tens_next;
        hour_ones <= hour_ones_next;
        pm        <= pm ^ pm_toggle;
      end
    end
  end

endmodule

// File: doc/time_keeper.md
Name: time_keeper

Overview:
- Downstream stage of the 1 Hz tick generator. Consumes its single-cycle `enable_second` pulse and maintains 12-hour time of day (hh:mm:ss plus AM/PM) as registered BCD digits.
- Outputs feed the seven-segment display multiplexer.
- Optional time-set inputs take pre-debounced, single-cycle button pulses.

Parameters:
- SEC_MAX, 59, last seconds value before wrap.
- MIN_MAX, 59, last minutes value before wrap.
- HOUR_MAX, 12, last hour value; hours count 1..HOUR_MAX.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- enable_second  in  1  one-cycle pulse, once per second.
- set_mode  in  1  level; high = clock halted for setting.
- inc_min  in  1  one-cycle pulse; advance minutes while setting.
- inc_hour  in  1  one-cycle pulse; advance hours while setting.
- sec_ones  out  4  BCD seconds units.
- sec_tens  out  4  BCD seconds tens.
- min_ones  out  4  BCD minutes units.
- min_tens  out  4  BCD minutes tens.
- hour_ones  out  4  BCD hours units.
- hour_tens  out  4  BCD hours tens; value 0 or 1 only.
- pm  out  1  0 = AM, 1 = PM.
- minute_tick  out  1  one-cycle pulse on every seconds wrap.

Behaviour:
- Clock and reset: one clock (`clk`). Reset is asynchronous and active-low (`rst_n`).
- Reset values:
  - Time = 12:00:00 AM, i.e. hour_tens=1, hour_ones=2, all other digits 0.
  - pm=0, minute_tick=0.
- Run mode (set_mode=0):
  - Each enable_second pulse advances seconds by 1.
  - All outputs are registered and update on the clk edge where enable_second=1 is sampled. Latency is 1 cycle; no combinational path from inputs to outputs.
- BCD counting:
  - Ones digit wraps 9->0 and carries into the tens digit.
  - Pair wraps at SEC_MAX/MIN_MAX (59->00).
  - Digits never hold a value above 9.
- Carry chain, all in the same cycle:
  - seconds 59->00: minute_tick=1 for exactly that cycle, minutes +1.
  - minutes 59->00: hours +1.
  - hours 12->01: no pm change.
  - hours 11->12: pm toggles (11:59:59 AM -> 12:00:00 PM; 11:59:59 PM -> 12:00:00 AM).
  - hours 09->10: tens=1, ones=0.
- Set mode (set_mode=1):
  - enable_second ignored; seconds forced to 00 on the first cycle set_mode is high and held there.
  - inc_min: minutes +1; 59->00 with no carry into hours.
  - inc_hour: hours +1 with the same 11->12 pm toggle; 12->01 rolls over.
  - inc_min and inc_hour in the same cycle: both apply independently.
  - minute_tick stays 0 in set mode.
- set_mode falling edge: counting resumes from the next enable_second. No pending tick is replayed.
- inc_min/inc_hour while set_mode=0: ignored.
- rst_n low mid-operation: immediate return to reset values regardless of mode. Input pulses during reset are lost.

Optional Feature:
- Macro: TIME_SET_EN.
- Defined: set_mode, inc_min and inc_hour behave as above.
- Undefined: those ports remain for a stable interface but are ignored; the block runs free from reset at 12:00:00 AM.

Decomposition:
- Package clock_pkg:
  - BCD digit type (4-bit).
  - Reset-time constants: RESET_HOUR_TENS=1, RESET_HOUR_ONES=2.
  - Default limits: 59, 12.
- Sub-module bcd_mod_counter: two-digit BCD counter with parameter MAX.
  - Inputs: inc, clr.
  - Outputs: ones, tens, wrap pulse (combinational with inc at MAX).
  - Instantiated for seconds and minutes.
- Hours (1..12 range, pm toggle) implemented inline in time_keeper.

Test Plan:
- Reset: assert rst_n=0 mid-count at 03:27:45 PM -> all outputs immediately read 12:00:00, pm=0, minute_tick=0.
- Seconds/minute carry: from 12:00:58, apply two enable_second pulses -> 12:00:59, then 12:01:00 with minute_tick high for exactly one cycle on the second pulse; outputs change one cycle after each sampled pulse.
- AM/PM boundaries:
  - 11:59:59 AM + 1 pulse -> 12:00:00, pm=1.
  - 12:59:59 PM + 1 pulse -> 01:00:00, pm=1.
  - 11:59:59 PM + 1 pulse -> 12:00:00, pm=0.
- Set mode: raise set_mode at 04:30:17 with enable_second pulses continuing -> seconds read 00, time frozen. Then:
  - 60 inc_min pulses -> minutes return to 30, hours stay 04.
  - 8 inc_hour pulses -> 12, pm toggled once.
- Simultaneous inputs: in set mode at 09:59:00, inc_min and inc_hour in the same cycle -> 10:00:00. In run mode, inc_min pulse -> no change.
- Macro off (TIME_SET_EN undefined): set_mode=1 plus inc pulses -> time keeps advancing on enable_second; no digit is affected by set inputs.
